// File: rtl/stream_burst_gate.sv
// Releases one host-requested burst from the SDRAM read stream into the pipe TX port
// through a 2-entry skid buffer, so that up_ready is registered and does not follow dn_ready.
//
// state  | meaning
// IDLE   | waiting for start; upstream closed
// RUN    | accepting words until len_q have been taken
// DRAIN  | upstream closed; emptying the skid buffer
// DONE   | one-cycle done pulse, then back to IDLE
module stream_burst_gate #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  words_sent,
    output logic                  up_ready,
    input  logic                  up_valid,
    input  logic [DATA_WIDTH-1:0] up_data,
    input  logic                  dn_ready,
    output logic                  dn_valid,
    output logic [DATA_WIDTH-1:0] dn_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q,      state_d;
    logic [LEN_WIDTH-1:0]  len_q,        len_d;
    logic [LEN_WIDTH-1:0]  acc_q,        acc_d;
    logic [LEN_WIDTH-1:0]  words_sent_q, words_sent_d;
    logic [1:0]            occ_q,        occ_d;
    logic [DATA_WIDTH-1:0] slot0_q,      slot0_d;
    logic [DATA_WIDTH-1:0] slot1_q,      slot1_d;
    logic                  dn_valid_q,   dn_valid_d;
    logic                  up_ready_q,   up_ready_d;
    logic                  busy_q,       busy_d;
    logic                  done_q,       done_d;

    logic push;
    logic pop;

    assign push = up_valid & up_ready_q;
    assign pop  = dn_valid_q & dn_ready;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        acc_d        = acc_q;
        words_sent_d = words_sent_q;
        occ_d        = occ_q;
        slot0_d      = slot0_q;
        slot1_d      = slot1_q;

        if (pop) begin
            words_sent_d = words_sent_q + 1'b1;
        end

        // slot0 is the head and drives dn_data directly
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    slot0_d = up_data;
                end else begin
                    slot1_d = up_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                if (occ_q == 2'd2) begin
                    slot0_d = slot1_q;
                end
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    slot0_d = slot1_q;
                    slot1_d = up_data;
                end else begin
                    slot0_d = up_data;
                end
            end
            default: begin
            end
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    words_sent_d = '0;
                    if (burst_len != '0) begin
                        len_d   = burst_len;
                        acc_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    occ_d   = 2'd0;
                    state_d = S_DONE;
                end else begin
                    if (push) begin
                        acc_d = acc_q + 1'b1;
                    end
                    if (acc_d == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    occ_d   = 2'd0;
                    state_d = S_DONE;
                end else if (occ_d == 2'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // registered ready only promises space that exists regardless of next cycle's pop
        up_ready_d = (state_d == S_RUN) && (acc_d < len_d) && (occ_d < 2'd2);
        dn_valid_d = (occ_d != 2'd0);
        busy_d     = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            acc_q        <= '0;
            words_sent_q <= '0;
            occ_q        <= 2'd0;
            slot0_q      <= '0;
            slot1_q      <= '0;
            dn_valid_q   <= 1'b0;
            up_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            acc_q        <= acc_d;
            words_sent_q <= words_sent_d;
            occ_q        <= occ_d;
            slot0_q      <= slot0_d;
            slot1_q      <= slot1_d;
            dn_valid_q   <= dn_valid_d;
            up_ready_q   <= up_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign words_sent = words_sent_q;
    assign up_ready   = up_ready_q;
    assign dn_valid   = dn_valid_q;
    assign dn_data    = slot0_q;

endmodule
